// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch unit: sequencer states and
// instruction-source mode constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } fetch_state_e;

    localparam logic MODE_EXT = 1'b0;
    localparam logic MODE_ROM = 1'b1;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous prefetch FIFO with flush; dout reads as zero while empty.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module instr_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction sequencer: external word source or PC-driven ROM prefetch into a
// small FIFO presented to the control unit with a valid/ready handshake.
//
//   state   | meaning
//   IDLE    | not fetching (reset, run low, mode change or external mode)
//   RUN     | issuing ROM reads while FIFO + in-flight has room
//   STOP    | last address fetched with wrapping disabled; waits for jump & run
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int INSTR_W    = 25,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter bit WRAP       = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               mode,
    input  logic [INSTR_W-1:0] ext_func,
    input  logic               ext_valid,
    output logic               ext_ready,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic [1:0]         state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_LAST = '1;
    localparam logic [ADDR_W-1:0] PC_ONE  = 1;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               mode_q;
    logic               inflight_q;
    logic               mode_chg;
    logic               rom_mode;
    logic               jump_rom;
    logic               flush;
    logic               issue;
    logic               at_end;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] push_data;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    logic               fifo_full;
    logic               fifo_empty;

    assign mode_chg  = (mode != mode_q);
    assign rom_mode  = (mode == MODE_ROM) && !mode_chg;
    assign jump_rom  = rom_mode && jump;
    assign flush     = mode_chg || jump_rom;
    assign at_end    = (pc_q == PC_LAST) && !WRAP;

    // The in-flight read already owns a FIFO slot, so a landing push can never overrun.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue     = rom_mode && !jump && (state_q == ST_RUN) &&
                       (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign ext_ready = (mode == MODE_EXT) && !mode_chg && !fifo_full;
    assign push      = (inflight_q && !flush) || (ext_valid && ext_ready);
    assign push_data = inflight_q ? mem_data : ext_func;
    assign pop       = instr_valid && instr_ready;

    assign mem_en      = issue;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign state       = state_q;
    assign instr_valid = !fifo_empty;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (mode_chg || (mode == MODE_EXT)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (run) state_d = ST_RUN;
                ST_RUN: begin
                    if (!run)                state_d = ST_IDLE;
                    else if (issue && at_end) state_d = ST_STOP;
                end
                ST_STOP: if (jump && run) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
        if (jump_rom)               pc_d = jump_addr;
        else if (issue && !at_end)  pc_d = pc_q + PC_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            mode_q     <= MODE_EXT;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mode_q     <= mode;
            inflight_q <= issue;
        end
    end

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     (push_data),
        .dout    (instr_out),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a wrapping and a stop-at-end instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int IW = 25;
    localparam int AW = 3;
    localparam int DEPTH = 4;
    localparam int LAST = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic          mode = 1'b1;
    logic [IW-1:0] ext_func = '0;
    logic          ext_valid = 1'b0;
    logic          jump = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic          instr_ready = 1'b1;

    logic          ext_ready_o   [2];
    logic          mem_en_o      [2];
    logic [AW-1:0] mem_addr_o    [2];
    logic [IW-1:0] instr_out_o   [2];
    logic          instr_valid_o [2];
    logic [AW-1:0] pc_o          [2];
    logic [1:0]    state_o       [2];

    int checks = 0;
    int errors = 0;
    int pops [2];

    // reference model: FIFO + in-flight as a queue of expected words
    int mq [2][$];
    int m_pc [2];
    int m_st [2];
    bit m_infl [2];
    int m_infl_addr [2];
    bit m_mode_q;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [IW-1:0] rom_q = '0;
        always @(posedge clk) if (mem_en_o[g]) rom_q <= IW'(32'h100 + 32'(mem_addr_o[g]));

        instr_fetch_unit #(
            .INSTR_W(IW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .WRAP(g == 0)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .run(run), .mode(mode),
            .ext_func(ext_func), .ext_valid(ext_valid), .ext_ready(ext_ready_o[g]),
            .mem_en(mem_en_o[g]), .mem_addr(mem_addr_o[g]), .mem_data(rom_q),
            .jump(jump), .jump_addr(jump_addr),
            .instr_out(instr_out_o[g]), .instr_valid(instr_valid_o[g]),
            .instr_ready(instr_ready), .pc(pc_o[g]), .state(state_o[g])
        );
    end

    function automatic bit m_issue(int k);
        return mode && (mode == m_mode_q) && !jump && (m_st[k] == 1) &&
               (mq[k].size() + int'(m_infl[k]) < DEPTH);
    endfunction

    function automatic bit m_ext_ready(int k);
        return !mode && (mode == m_mode_q) && (mq[k].size() < DEPTH);
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_pc[k] = 0;
            m_st[k] = 0;
            m_infl[k] = 1'b0;
        end
        m_mode_q = 1'b0;
    endtask

    task automatic m_step(int k);
        bit mchg, jr, iss, pop_m, push_x, land;
        int old_pc;
        mchg   = (mode != m_mode_q);
        jr     = mode && !mchg && jump;
        iss    = m_issue(k);
        pop_m  = (mq[k].size() > 0) && instr_ready;
        push_x = ext_valid && m_ext_ready(k);
        land   = m_infl[k] && !(mchg || jr);
        old_pc = m_pc[k];
        if (mchg || jr) mq[k].delete();
        else begin
            if (pop_m)  void'(mq[k].pop_front());
            if (land)   mq[k].push_back(32'h100 + m_infl_addr[k]);
            if (push_x) mq[k].push_back(int'(ext_func));
        end
        if (mchg || !mode)                     m_st[k] = 0;
        else if (m_st[k] == 0 && run)          m_st[k] = 1;
        else if (m_st[k] == 1 && !run)         m_st[k] = 0;
        else if (m_st[k] == 1 && iss && k == 1 && old_pc == LAST) m_st[k] = 2;
        else if (m_st[k] == 2 && jump && run)  m_st[k] = 1;
        if (jr)       m_pc[k] = int'(jump_addr);
        else if (iss) m_pc[k] = (k == 0) ? (old_pc + 1) % 8 : ((old_pc == LAST) ? LAST : old_pc + 1);
        m_infl[k]      = iss;
        m_infl_addr[k] = old_pc;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("instr_valid", k, 32'(instr_valid_o[k]), 32'(mq[k].size() > 0));
            chk("instr_out", k, 32'(instr_out_o[k]), (mq[k].size() > 0) ? 32'(mq[k][0]) : 32'd0);
            chk("pc", k, 32'(pc_o[k]), 32'(m_pc[k]));
            chk("state", k, 32'(state_o[k]), 32'(m_st[k]));
            chk("mem_en", k, 32'(mem_en_o[k]), 32'(m_issue(k)));
            if (m_issue(k)) chk("mem_addr", k, 32'(mem_addr_o[k]), 32'(m_pc[k]));
            chk("ext_ready", k, 32'(ext_ready_o[k]), 32'(m_ext_ready(k)));
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) if (instr_valid_o[k] && instr_ready) pops[k]++;
        @(posedge clk);
        if (!reset_n) m_clear();
        else begin
            m_step(0);
            m_step(1);
            m_mode_q = mode;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        m_clear();
        ticks(2);
        reset_n = 1'b1;
        ticks(2);

        // ROM sequential fetch, consumer always ready
        pops[0] = 0; pops[1] = 0;
        run = 1'b1;
        ticks(16);
        chk("stop_count", 1, 32'(pops[1]), 32'd8);
        chk("stop_state", 1, 32'(state_o[1]), 32'd2);

        // restart stop-at-end instance from address 5
        pops[1] = 0;
        jump = 1'b1; jump_addr = 3'd5;
        tick();
        jump = 1'b0;
        ticks(8);
        chk("jump5_count", 1, 32'(pops[1]), 32'd3);

        // backpressure: fill FIFO then release
        jump = 1'b1; jump_addr = 3'd0;
        tick();
        jump = 1'b0; instr_ready = 1'b0;
        ticks(10);
        instr_ready = 1'b1;
        ticks(10);

        // jump while FIFO partly full with a read in flight
        instr_ready = 1'b0;
        jump = 1'b1; jump_addr = 3'd0;
        tick();
        jump = 1'b0;
        ticks(3);
        jump = 1'b1; jump_addr = 3'd2;
        tick();
        jump = 1'b0; instr_ready = 1'b1;
        ticks(6);

        // external source mode
        mode = 1'b0;
        tick();
        ext_valid = 1'b1; ext_func = 25'h0ABCDE;
        tick();
        ext_func = 25'h012345;
        tick();
        ext_valid = 1'b0;
        ticks(3);
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ext_valid = 1'b1; ext_func = IW'($urandom);
            tick();
        end
        ext_valid = 1'b0; instr_ready = 1'b1;
        ticks(6);

        // mode change mid-run
        mode = 1'b1; run = 1'b1;
        ticks(6);
        mode = 1'b0;
        ticks(2);
        mode = 1'b1;
        ticks(6);

        // randomized mix
        for (int i = 0; i < 400; i++) begin
            run         = ($urandom_range(0, 7) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            jump        = ($urandom_range(0, 9) == 0);
            jump_addr   = AW'($urandom);
            ext_valid   = $urandom_range(0, 1) == 1;
            ext_func    = IW'($urandom);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            tick();
        end

        // asynchronous reset mid-run
        mode = 1'b1; run = 1'b1; jump = 1'b0; ext_valid = 1'b0; instr_ready = 1'b0;
        ticks(6);
        reset_n = 1'b0;
        #1;
        m_clear();
        check_all();
        ticks(2);
        reset_n = 1'b1;
        instr_ready = 1'b1;
        ticks(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
